// File: rtl/m_load_unit.sv
// m_load_unit: single-outstanding load unit between the pipeline and a
// word-wide bus. Classifies alignment when a load is accepted, issues one or
// two word reads, extracts and extends the addressed byte/half/word, and
// reports done with optional address-error or timeout flags.
//
// Optional feature macro: LOAD_UNALIGNED_EN
//   undefined : misaligned lw/lh/lhu completes at once with excAdEL=1
//   defined   : misaligned loads are serviced (one or two bus beats)
//
// Handshake: busReq/busAddr are held steady from entry to a REQ state until
// the cycle in which busAck is sampled high; busRdata is taken in that same
// cycle. busAck is ignored while busReq is low.
module m_load_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [2:0]  loadOp,
  input  logic        flush,
  output logic        busReq,
  output logic [31:0] busAddr,
  input  logic [31:0] busRdata,
  input  logic        busAck,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        excAdEL,
  output logic        timeout,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ0 = 2'd1,
    REQ1 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] wait_cnt;
  logic [1:0]  off_q;
  logic [2:0]  op_q;
  logic        two_beat_q;
  logic [31:0] word0_q;
  logic        exc_q;
  logic        to_q;

  logic        is_rsv;
  logic        is_word;
  logic        is_half;
  logic        acc_fault;
  logic        acc_two;
  logic        wait_last;
  logic        enter_done;
  logic [55:0] pair;
  logic [31:0] win;
  logic [31:0] ext;

  // Decode of the incoming request, used only while IDLE.
  assign is_rsv  = (loadOp > 3'd4);
  assign is_word = (loadOp == 3'b000);
  assign is_half = (loadOp == 3'b001) || (loadOp == 3'b011);

`ifdef LOAD_UNALIGNED_EN
  // Every access is serviced; a word straddling two words or a half at
  // offset 3 needs a second beat at the following word.
  assign acc_fault = 1'b0;
  assign acc_two   = (is_word && (addr[1:0] != 2'b00)) ||
                     (is_half && (addr[1:0] == 2'b11));
`else
  // Misaligned word/half is an address error; no bus traffic.
  assign acc_fault = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
  assign acc_two   = 1'b0;
`endif

  assign wait_last  = (wait_cnt == 16'(MAX_WAIT - 1));
  assign enter_done = (state_nx == DONE) && (state != DONE);

  // Next-state logic; flush wins over everything except reset.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = (is_rsv || acc_fault) ? DONE : REQ0;
      REQ0: begin
        if (busAck)         state_nx = two_beat_q ? REQ1 : DONE;
        else if (wait_last) state_nx = DONE;
      end
      REQ1: if (busAck || wait_last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Byte window selection over {second word, first word}, then extension.
  always_comb begin
    pair = two_beat_q ? {busRdata[23:0], word0_q} : {24'b0, busRdata};
    case (off_q)
      2'd0:    win = pair[31:0];
      2'd1:    win = pair[39:8];
      2'd2:    win = pair[47:16];
      default: win = pair[55:24];
    endcase
    case (op_q)
      3'b000:  ext = win;
      3'b001:  ext = {{16{win[15]}}, win[15:0]};
      3'b010:  ext = {{24{win[7]}}, win[7:0]};
      3'b011:  ext = {16'b0, win[15:0]};
      3'b100:  ext = {24'b0, win[7:0]};
      default: ext = 32'b0;
    endcase
  end

  // State, request context, bus address and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 16'd0;
      off_q      <= 2'd0;
      op_q       <= 3'd0;
      two_beat_q <= 1'b0;
      word0_q    <= 32'b0;
      busAddr    <= 32'b0;
      rdata      <= 32'b0;
      exc_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state <= state_nx;

      if (state_nx != state)
        wait_cnt <= 16'd0;
      else if ((state == REQ0) || (state == REQ1))
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= 16'd0;

      if ((state == IDLE) && req && !flush) begin
        off_q      <= addr[1:0];
        op_q       <= loadOp;
        two_beat_q <= acc_two;
        busAddr    <= {addr[31:2], 2'b00};
      end

      if ((state == REQ0) && busAck && two_beat_q && !flush) begin
        word0_q <= busRdata;
        busAddr <= busAddr + 32'd4;
      end

      if (enter_done)
        rdata <= ((state != IDLE) && busAck) ? ext : 32'b0;

      exc_q <= enter_done && (state == IDLE) && acc_fault;
      to_q  <= enter_done && (state != IDLE) && !busAck;
    end
  end

  assign busReq    = (state == REQ0) || (state == REQ1);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) && !flush;
  assign excAdEL   = exc_q;
  assign timeout   = to_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_m_load_unit.sv
// Bench for m_load_unit: directed scenarios plus randomized loads checked
// against a cycle-plan reference model derived from the load rules.
module tb_m_load_unit;

  localparam int MW = 4;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [2:0]  loadOp;
  logic        flush;
  logic        busReq;
  logic [31:0] busAddr;
  logic [31:0] busRdata;
  logic        busAck;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        excAdEL;
  logic        timeout;
  logic [1:0]  state_dbg;

  int          n_cmp;
  int          n_err;
  logic [31:0] last_rdata;
  logic [31:0] exp_q[$];

  m_load_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .loadOp(loadOp),
    .flush(flush), .busReq(busReq), .busAddr(busAddr), .busRdata(busRdata),
    .busAck(busAck), .rdata(rdata), .done(done), .busy(busy),
    .excAdEL(excAdEL), .timeout(timeout), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian window of {w1,w0} at byte offset, then extension.
  function automatic logic [31:0] model_rdata(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] p;
    logic [31:0] r;
    p = {w1, w0};
    r = 32'(p >> (8 * off));
    case (op)
      3'b000:  return r;
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b010:  return {{24{r[7]}}, r[7:0]};
      3'b011:  return {16'b0, r[15:0]};
      3'b100:  return {24'b0, r[7:0]};
      default: return 32'b0;
    endcase
  endfunction

  // Drives one load; d0/d1 = cycles of waiting before each beat's ack
  // (>= MW means that beat is never acked).
  task automatic run_load(input logic [31:0] a, input logic [2:0] op,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input int d0, input int d1);
    int ack0, ack1, end0, st1, end1, done_cyc;
    logic rsv, fault, two, to, exp_breq;
    logic [1:0] off;
    logic [31:0] b0, exp_r;
    rsv = (op > 3'd4);
    off = a[1:0];
`ifdef LOAD_UNALIGNED_EN
    fault = 1'b0;
    two   = ((op == 3'd0) && (off != 2'd0)) || (((op == 3'd1) || (op == 3'd3)) && (off == 2'd3));
`else
    fault = ((op == 3'd0) && (off != 2'd0)) || (((op == 3'd1) || (op == 3'd3)) && off[0]);
    two   = 1'b0;
`endif
    ack0 = -1; ack1 = -1; end0 = 0; st1 = 0; end1 = 0; to = 1'b0;
    if (rsv || fault) done_cyc = 1;
    else if (d0 >= MW) begin
      end0 = MW; done_cyc = MW + 1; to = 1'b1;
    end else begin
      ack0 = 1 + d0; end0 = ack0;
      if (two) begin
        st1 = ack0 + 1;
        if (d1 >= MW) begin end1 = st1 + MW - 1; done_cyc = st1 + MW; to = 1'b1; end
        else begin ack1 = st1 + d1; end1 = ack1; done_cyc = ack1 + 1; end
      end else done_cyc = ack0 + 1;
    end
    exp_r = (rsv || fault || to) ? 32'b0 : model_rdata(op, off, w0, w1);
    exp_q.push_back(exp_r);
    b0 = {a[31:2], 2'b00};

    @(posedge clk); #1;
    req = 1'b1; addr = a; loadOp = op;
    busAck = 1'($urandom_range(0, 1)); busRdata = $urandom;
    #3;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_busreq", 32'(busReq), 32'd0);

    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(posedge clk); #1;
      if (c <= done_cyc) begin
        req = 1'($urandom_range(0, 1)); addr = $urandom; loadOp = 3'($urandom_range(0, 7));
      end else req = 1'b0;
      busAck   = (c == ack0) || (c == ack1) || (c == done_cyc);
      busRdata = (c == ack0) ? w0 : (c == ack1) ? w1 : $urandom;
      #3;
      exp_breq = ((c >= 1) && (c <= end0)) || ((st1 != 0) && (c >= st1) && (c <= end1));
      check("busreq", 32'(busReq), 32'(exp_breq));
      if (exp_breq) check("busaddr", busAddr, (c <= end0) ? b0 : b0 + 32'd4);
      check("done", 32'(done), 32'(c == done_cyc));
      check("busy", 32'(busy), 32'(c <= done_cyc));
      if (c == done_cyc) begin
        exp_r = exp_q.pop_front();
        check("rdata", rdata, exp_r);
        check("excadel", 32'(excAdEL), 32'(fault));
        check("timeout", 32'(timeout), 32'(to));
        last_rdata = exp_r;
      end
      if (c == done_cyc + 1) check("rdata_hold", rdata, last_rdata);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; last_rdata = 32'b0;
    reset = 1'b1; req = 1'b0; addr = 32'b0; loadOp = 3'b0; flush = 1'b0;
    busAck = 1'b0; busRdata = 32'b0;

    // Reset
    repeat (2) @(posedge clk);
    #4;
    check("rst_busreq", 32'(busReq), 32'd0);
    check("rst_busaddr", busAddr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_exc", 32'(excAdEL), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Directed loads
    run_load(32'h0000_1003, 3'b010, 32'h80FF_1234, 32'h0, 1, 0);
    run_load(32'h0000_2002, 3'b011, 32'hBEEF_0000, 32'h0, 0, 0);
    run_load(32'h0000_3001, 3'b000, 32'h1234_5678, 32'h0, 0, 0);
    run_load(32'hFFFF_FFFE, 3'b000, 32'h1122_3344, 32'h5566_7788, 0, 0);
    run_load(32'h0000_4000, 3'b000, 32'hDEAD_BEEF, 32'h0, 9, 0);
    run_load(32'h0000_5000, 3'b110, 32'hDEAD_BEEF, 32'h0, 0, 0);
    run_load(32'h0000_6003, 3'b001, 32'h8000_0000, 32'h0000_00FF, 2, 9);

    // Flush together with busAck during REQ0: no done, rdata unchanged
    @(posedge clk); #1 req = 1'b1; addr = 32'h0000_7000; loadOp = 3'b000;
    @(posedge clk); #1 req = 1'b0;
    #3 check("fl_busreq_before", 32'(busReq), 32'd1);
    @(posedge clk); #1 flush = 1'b1; busAck = 1'b1; busRdata = 32'hCAFE_F00D;
    #3 check("fl_done_same", 32'(done), 32'd0);
    @(posedge clk); #1 flush = 1'b0; busAck = 1'b0;
    #3;
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_busreq", 32'(busReq), 32'd0);
    check("fl_done", 32'(done), 32'd0);
    check("fl_rdata", rdata, last_rdata);
    @(posedge clk); #4 check("fl_done_late", 32'(done), 32'd0);

    // Flush overrides a same-cycle req in IDLE
    @(posedge clk); #1 req = 1'b1; flush = 1'b1; addr = 32'h0000_7100; loadOp = 3'b010;
    @(posedge clk); #1 req = 1'b0; flush = 1'b0;
    #3 check("fl_req_busy", 32'(busy), 32'd0);

    // Reset mid-transfer beats a same-cycle busAck
    @(posedge clk); #1 req = 1'b1; addr = 32'h0000_8004; loadOp = 3'b000;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 reset = 1'b1; busAck = 1'b1; busRdata = 32'h1357_9BDF;
    @(posedge clk); #1 reset = 1'b0; busAck = 1'b0;
    #3;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_busreq", 32'(busReq), 32'd0);
    check("mr_busaddr", busAddr, 32'd0);
    check("mr_rdata", rdata, 32'd0);
    check("mr_done", 32'(done), 32'd0);
    last_rdata = 32'b0;

    // Randomized loads
    for (int i = 0; i < 80; i++) begin
      run_load($urandom, 3'($urandom_range(0, 7)), $urandom, $urandom,
               $urandom_range(0, MW + 1), $urandom_range(0, MW + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
